memcpy_queue_ctrl: RTL and testbench
====================================

MEMCPY_QUEUE_CTRL -- requirements
Module: memcpy_queue_ctrl

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, meaning the descriptor queue depth (power of 2, at least 2).
REQ-002 SHALL have parameter LEN_W, default 32, meaning the byte-length field width.
REQ-003 SHALL have parameter ADDR_W, default 42, meaning the cache-line address width.
REQ-004 SHALL have parameter DATA_W, default 512, meaning the data beat width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-006 SHALL have port reset, input, 1, the reset; it is synchronous and active-low.
REQ-007 SHALL have port csr_wr_en, input, 1, a CSR write strobe.
REQ-008 SHALL have port csr_wr_idx, input, 3, the CSR index.
REQ-009 SHALL have port csr_wr_data, input, 64, the CSR write data.
REQ-010 SHALL have port csr_rd_data, output, 6x64, the read-back CSRs (index 0-5).
REQ-011 SHALL have port dma_start, output, 1, a one-cycle command pulse.
REQ-012 SHALL have ports dma_rd_addr and dma_wr_addr, output, ADDR_W each, the command addresses.
REQ-013 SHALL have port dma_len, output, LEN_W-6, the command length in lines.
REQ-014 SHALL have port dma_done, input, 1, a one-cycle pulse signalling command completion.
REQ-015 SHALL have ports rd_data, rd_valid (input) and rd_ready (output), the read-side stream.
REQ-016 SHALL have ports wr_data, wr_valid (output) and wr_ready (input), the write-side stream.

Function
REQ-017 SHALL latch staging registers from CSR writes: idx0 SRC (data[ADDR_W-1:0]), idx1 DST, idx2 LEN bytes (data[LEN_W-1:0]).
REQ-018 SHALL treat a write to idx3 (DOORBELL) as a push of {SRC, DST, LEN, mode=data[0]} into the queue; staging registers are unchanged by the push.
REQ-019 SHALL drop a push when the queue is full and set a sticky overflow bit; a write to idx3 with data[63]=1 clears overflow and pushes nothing.
REQ-020 SHALL accept a push when it coincides with a pop while the queue is full.
REQ-021 SHALL run an FSM with states IDLE, ISSUE, BUSY and CPL.
REQ-022 SHALL transition IDLE->ISSUE when the queue is non-empty; the head is popped into active registers on this transition.
REQ-023 SHALL, in ISSUE, compute lines = (LEN+63)>>6 (rounding up a partial line); if lines==0 go ->CPL with no dma_start, else assert dma_start for exactly 1 cycle and go ->BUSY.
REQ-024 SHALL hold dma_rd_addr, dma_wr_addr and dma_len stable from ISSUE until leaving BUSY.
REQ-025 SHALL go BUSY->CPL on dma_done; dma_done in any state other than BUSY is ignored.
REQ-026 SHALL, in CPL, increment the 32-bit completion counter (wrapping 0xFFFFFFFF->0) and go ->IDLE; minimum spacing between two dma_start pulses is 4 cycles.
REQ-027 SHALL drive the CSR readback as: idx0 completion count; idx1 {overflow[8], busy[7], queue count[6:0]}; idx2 active SRC; idx3 active DST; idx4 active lines; idx5 the constant QDEPTH.
REQ-028 SHALL use a data path with a single register stage: rd_ready = !wr_valid || wr_ready; a beat loads when rd_valid && rd_ready.
REQ-029 SHALL set the data transform by mode: 0 copies the beat unchanged, 1 gives wr_data = ~rd_data; mode is taken from the active descriptor.
REQ-030 SHALL keep wr_data stable while wr_valid && !wr_ready, with no beat lost or duplicated.

Reset
REQ-031 SHALL, while reset==0 at a clock edge, set: FSM IDLE, queue empty, overflow 0, counter 0, staging and active registers 0, dma_start 0, wr_valid 0.
REQ-032 SHALL, on reset mid-operation, discard queued and active descriptors; a dma_done arriving after reset is ignored.

Structure
REQ-033 SHALL place the descriptor typedef, the FSM state enum and the CSR index constants in shared package memcpy_queue_pkg.
REQ-034 SHALL implement the queue as the sub-module memcpy_desc_fifo (parametrised by QDEPTH and descriptor type, with full, empty and count outputs).

Verification
REQ-035 SHALL cover a single job: SRC=0x1000, DST=0x2000, LEN=256, doorbell -> one dma_start with dma_len=4; dma_done -> idx0 reads 1.
REQ-036 SHALL cover rounding and zero length: LEN=65 -> dma_len=2; LEN=0 -> no dma_start and the counter increments.
REQ-037 SHALL cover overflow: with QDEPTH=4 and the FSM held in BUSY, 6 doorbells -> count=4, overflow=1; 5 dma_done pulses -> counter=5 and the 6th job is lost.
REQ-038 SHALL cover full plus pop: a doorbell in the same cycle as the IDLE->ISSUE pop with the queue full -> the push is accepted and overflow stays 0.
REQ-039 SHALL cover backpressure: mode=1, rd_data=0xA5.., wr_ready held low 3 cycles -> wr_data=0x5A.. held stable, then a single transfer.
REQ-040 SHALL cover reset mid-operation: reset asserted in BUSY with 2 queued jobs -> all outputs at their reset values, and a later dma_done leaves the counter at 0.

Source files
------------

// File: rtl/memcpy_queue_pkg.sv
// Shared types for the memcpy descriptor queue controller: descriptor layout,
// FSM states, CSR indices and the byte-to-line rounding helper.
package memcpy_queue_pkg;

  // Fields are held at CSR width; the controller zero-extends narrower values.
  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
    logic [63:0] len;
    logic        mode;
  } desc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_CPL   = 2'd3
  } state_t;

  localparam logic [2:0] CSR_SRC      = 3'd0;
  localparam logic [2:0] CSR_DST      = 3'd1;
  localparam logic [2:0] CSR_LEN      = 3'd2;
  localparam logic [2:0] CSR_DOORBELL = 3'd3;

  localparam logic [2:0] CSR_RD_CPL_CNT = 3'd0;
  localparam logic [2:0] CSR_RD_STATUS  = 3'd1;
  localparam logic [2:0] CSR_RD_SRC     = 3'd2;
  localparam logic [2:0] CSR_RD_DST     = 3'd3;
  localparam logic [2:0] CSR_RD_LINES   = 3'd4;
  localparam logic [2:0] CSR_RD_QDEPTH  = 3'd5;
  localparam int         CSR_RD_NUM     = 6;

  // Byte length to 64-byte lines, rounding a partial line up.
  function automatic logic [63:0] lines_of(input logic [63:0] len_bytes);
    return (len_bytes + 64'd63) >> 6;
  endfunction

endpackage

// File: rtl/memcpy_queue_ctrl_if.sv
// DMA command and read/write stream signals of the memcpy queue controller.
interface memcpy_queue_ctrl_if #(
  parameter int ADDR_W = 42,
  parameter int LEN_W  = 32,
  parameter int DATA_W = 512
);
  logic              dma_start;
  logic [ADDR_W-1:0] dma_rd_addr;
  logic [ADDR_W-1:0] dma_wr_addr;
  logic [LEN_W-7:0]  dma_len;
  logic              dma_done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  modport master (
    output dma_start, dma_rd_addr, dma_wr_addr, dma_len, rd_ready, wr_data, wr_valid,
    input  dma_done, rd_data, rd_valid, wr_ready
  );

  modport slave (
    input  dma_start, dma_rd_addr, dma_wr_addr, dma_len, rd_ready, wr_data, wr_valid,
    output dma_done, rd_data, rd_valid, wr_ready
  );
endinterface

// File: rtl/memcpy_desc_fifo.sv
// Descriptor FIFO; a push into a full queue is accepted when a pop frees a slot
// in the same cycle.
module memcpy_desc_fifo #(
  parameter int  QDEPTH = 4,
  parameter type DESC_T = memcpy_queue_pkg::desc_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  DESC_T                    din,
  output DESC_T                    dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(QDEPTH):0]  count
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  DESC_T            mem_r [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (count_r == {CNT_W{1'b0}});
  assign full      = (count_r == CNT_W'(QDEPTH));
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/memcpy_queue_ctrl.sv
// Memcpy queue controller: CSR-fed descriptor queue, DMA command sequencing and
// a single-stage copy/invert data path.
module memcpy_queue_ctrl
  import memcpy_queue_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int LEN_W  = 32,
  parameter int ADDR_W = 42,
  parameter int DATA_W = 512
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         csr_wr_en,
  input  logic [2:0]                   csr_wr_idx,
  input  logic [63:0]                  csr_wr_data,
  output logic [CSR_RD_NUM-1:0][63:0]  csr_rd_data,
  memcpy_queue_ctrl_if.master          bus
);
  localparam int LINES_W = LEN_W - 5;
  localparam int CNT_W   = $clog2(QDEPTH) + 1;

  logic [ADDR_W-1:0]  stg_src_r;
  logic [ADDR_W-1:0]  stg_dst_r;
  logic [LEN_W-1:0]   stg_len_r;
  logic [ADDR_W-1:0]  act_src_r;
  logic [ADDR_W-1:0]  act_dst_r;
  logic [LINES_W-1:0] act_lines_r;
  logic               act_mode_r;
  state_t             state_r;
  logic               dma_start_r;
  logic               overflow_r;
  logic [31:0]        cpl_cnt_r;
  logic [DATA_W-1:0]  wr_data_r;
  logic               wr_valid_r;

  desc_t              push_desc_s;
  desc_t              head_s;
  logic               doorbell_s;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic [CNT_W-1:0]   count_s;
  logic [63:0]        head_lines_s;
  logic               rd_ready_s;
  logic               unused_bits_s;

  assign doorbell_s   = csr_wr_en && (csr_wr_idx == CSR_DOORBELL);
  assign push_s       = doorbell_s && !csr_wr_data[63];
  assign pop_s        = (state_r == ST_IDLE) && !empty_s;
  assign head_lines_s = lines_of(head_s.len);

  assign push_desc_s.src  = 64'(stg_src_r);
  assign push_desc_s.dst  = 64'(stg_dst_r);
  assign push_desc_s.len  = 64'(stg_len_r);
  assign push_desc_s.mode = csr_wr_data[0];

  memcpy_desc_fifo #(
    .QDEPTH (QDEPTH),
    .DESC_T (desc_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_desc_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Staging registers written directly from the CSR port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stg_src_r <= {ADDR_W{1'b0}};
      stg_dst_r <= {ADDR_W{1'b0}};
      stg_len_r <= {LEN_W{1'b0}};
    end else if (csr_wr_en) begin
      case (csr_wr_idx)
        CSR_SRC: stg_src_r <= csr_wr_data[ADDR_W-1:0];
        CSR_DST: stg_dst_r <= csr_wr_data[ADDR_W-1:0];
        CSR_LEN: stg_len_r <= csr_wr_data[LEN_W-1:0];
        default: stg_len_r <= stg_len_r;
      endcase
    end
  end

  // Sticky overflow: a push is lost only when full with no pop in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_r <= 1'b0;
    end else if (doorbell_s && csr_wr_data[63]) begin
      overflow_r <= 1'b0;
    end else if (push_s && full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Command sequencer; dma_start is registered so it is high for the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      dma_start_r <= 1'b0;
      act_src_r   <= {ADDR_W{1'b0}};
      act_dst_r   <= {ADDR_W{1'b0}};
      act_lines_r <= {LINES_W{1'b0}};
      act_mode_r  <= 1'b0;
      cpl_cnt_r   <= 32'd0;
    end else begin
      dma_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            act_src_r   <= head_s.src[ADDR_W-1:0];
            act_dst_r   <= head_s.dst[ADDR_W-1:0];
            act_lines_r <= head_lines_s[LINES_W-1:0];
            act_mode_r  <= head_s.mode;
            dma_start_r <= (head_lines_s[LINES_W-1:0] != {LINES_W{1'b0}});
            state_r     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_r <= (act_lines_r == {LINES_W{1'b0}}) ? ST_CPL : ST_BUSY;
        end
        ST_BUSY: begin
          if (bus.dma_done) begin
            state_r <= ST_CPL;
          end
        end
        ST_CPL: begin
          cpl_cnt_r <= cpl_cnt_r + 32'd1;
          state_r   <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign rd_ready_s = !wr_valid_r || bus.wr_ready;

  // Single output register; a new beat may load in the cycle the old one leaves.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_valid_r <= 1'b0;
      wr_data_r  <= {DATA_W{1'b0}};
    end else if (bus.rd_valid && rd_ready_s) begin
      wr_valid_r <= 1'b1;
      wr_data_r  <= act_mode_r ? ~bus.rd_data : bus.rd_data;
    end else if (bus.wr_ready) begin
      wr_valid_r <= 1'b0;
    end
  end

  assign bus.dma_start   = dma_start_r;
  assign bus.dma_rd_addr = act_src_r;
  assign bus.dma_wr_addr = act_dst_r;
  assign bus.dma_len     = act_lines_r[LEN_W-7:0];
  assign bus.rd_ready    = rd_ready_s;
  assign bus.wr_data     = wr_data_r;
  assign bus.wr_valid    = wr_valid_r;

  assign csr_rd_data[CSR_RD_CPL_CNT] = {32'd0, cpl_cnt_r};
  assign csr_rd_data[CSR_RD_STATUS]  = {55'd0, overflow_r, (state_r != ST_IDLE), 7'(count_s)};
  assign csr_rd_data[CSR_RD_SRC]     = 64'(act_src_r);
  assign csr_rd_data[CSR_RD_DST]     = 64'(act_dst_r);
  assign csr_rd_data[CSR_RD_LINES]   = 64'(act_lines_r);
  assign csr_rd_data[CSR_RD_QDEPTH]  = 64'(QDEPTH);

  // Descriptor and CSR bits wider than the configured fields are intentionally dropped.
  assign unused_bits_s = ^{csr_wr_data, head_s, head_lines_s};
endmodule

// File: tb/tb_memcpy_queue_ctrl.sv
// Directed bench for memcpy_queue_ctrl with hand-computed expectations.
module tb_memcpy_queue_ctrl;
  import memcpy_queue_pkg::*;

  localparam int QDEPTH = 4;
  localparam int LEN_W  = 32;
  localparam int ADDR_W = 42;
  localparam int DATA_W = 512;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic                        csr_wr_en = 1'b0;
  logic [2:0]                  csr_wr_idx = 3'd0;
  logic [63:0]                 csr_wr_data = 64'd0;
  logic [CSR_RD_NUM-1:0][63:0] csr_rd_data;

  int check_cnt = 0;
  int fail_cnt  = 0;
  int start_cnt = 0;
  int xfer_cnt  = 0;
  int s0;
  int x0;
  logic [LEN_W-7:0]  last_len  = '0;
  logic [DATA_W-1:0] xfer_last = '0;
  logic [DATA_W-1:0] xfer_prev = '0;
  logic [DATA_W-1:0] pat_a5;
  logic [DATA_W-1:0] pat_5a;
  logic [DATA_W-1:0] pat_3c;
  logic [DATA_W-1:0] pat_c3;
  logic [DATA_W-1:0] pat_d;

  always #5 clk = ~clk;

  memcpy_queue_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

  memcpy_queue_ctrl #(
    .QDEPTH (QDEPTH),
    .LEN_W  (LEN_W),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .csr_wr_en   (csr_wr_en),
    .csr_wr_idx  (csr_wr_idx),
    .csr_wr_data (csr_wr_data),
    .csr_rd_data (csr_rd_data),
    .bus         (bus)
  );

  // Count command pulses and write-side transfers as seen at the clock edge.
  always @(posedge clk) begin
    if (bus.dma_start) begin
      start_cnt <= start_cnt + 1;
      last_len  <= bus.dma_len;
    end
    if (bus.wr_valid && bus.wr_ready) begin
      xfer_cnt  <= xfer_cnt + 1;
      xfer_prev <= xfer_last;
      xfer_last <= bus.wr_data;
    end
  end

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    check_cnt = check_cnt + 1;
    if (obs !== exp) begin
      fail_cnt = fail_cnt + 1;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [2:0] idx, input logic [63:0] data);
    @(negedge clk);
    csr_wr_en   = 1'b1;
    csr_wr_idx  = idx;
    csr_wr_data = data;
    @(posedge clk);
    #1;
    csr_wr_en = 1'b0;
  endtask

  task automatic setup_job(input logic [63:0] src, input logic [63:0] dst, input logic [63:0] len);
    csr_write(CSR_SRC, src);
    csr_write(CSR_DST, dst);
    csr_write(CSR_LEN, len);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    bus.dma_done = 1'b1;
    @(negedge clk);
    bus.dma_done = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset        = 1'b0;
    bus.rd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    pat_a5 = {64{8'hA5}};
    pat_5a = {64{8'h5A}};
    pat_3c = {64{8'h3C}};
    pat_c3 = {64{8'hC3}};
    pat_d  = {8{64'h0123_4567_89AB_CDEF}};
    bus.dma_done = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    bus.wr_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_cnt",    512'(csr_rd_data[0]), 512'(64'd0));
    check_val("rst_status", 512'(csr_rd_data[1]), 512'(64'd0));
    check_val("rst_src",    512'(csr_rd_data[2]), 512'(64'd0));
    check_val("rst_lines",  512'(csr_rd_data[4]), 512'(64'd0));
    check_val("rst_qdepth", 512'(csr_rd_data[5]), 512'(64'd4));
    check_val("rst_start",  512'(bus.dma_start),  512'(1'b0));
    check_val("rst_wvalid", 512'(bus.wr_valid),   512'(1'b0));
    reset = 1'b1;

    // Single 256-byte job
    setup_job(64'h1000, 64'h2000, 64'd256);
    s0 = start_cnt;
    csr_write(CSR_DOORBELL, 64'd0);
    repeat (3) @(negedge clk);
    check_val("j1_starts",  512'(start_cnt - s0),   512'(1));
    check_val("j1_len",     512'(last_len),         512'(26'd4));
    check_val("j1_rdaddr",  512'(bus.dma_rd_addr),  512'(42'h1000));
    check_val("j1_wraddr",  512'(bus.dma_wr_addr),  512'(42'h2000));
    check_val("j1_csr_src", 512'(csr_rd_data[2]),   512'(64'h1000));
    check_val("j1_csr_dst", 512'(csr_rd_data[3]),   512'(64'h2000));
    check_val("j1_status",  512'(csr_rd_data[1]),   512'(64'h080));
    pulse_done();
    repeat (2) @(negedge clk);
    check_val("j1_cnt",     512'(csr_rd_data[0]),   512'(64'd1));
    check_val("j1_idle",    512'(csr_rd_data[1]),   512'(64'd0));

    // 65 bytes rounds up to two lines
    csr_write(CSR_LEN, 64'd65);
    s0 = start_cnt;
    csr_write(CSR_DOORBELL, 64'd0);
    repeat (3) @(negedge clk);
    check_val("r65_starts", 512'(start_cnt - s0),   512'(1));
    check_val("r65_len",    512'(last_len),         512'(26'd2));
    check_val("r65_lines",  512'(csr_rd_data[4]),   512'(64'd2));
    pulse_done();
    repeat (2) @(negedge clk);
    check_val("r65_cnt",    512'(csr_rd_data[0]),   512'(64'd2));

    // Zero length completes without a command
    csr_write(CSR_LEN, 64'd0);
    s0 = start_cnt;
    csr_write(CSR_DOORBELL, 64'd0);
    repeat (4) @(negedge clk);
    check_val("z_starts",   512'(start_cnt - s0),   512'(0));
    check_val("z_cnt",      512'(csr_rd_data[0]),   512'(64'd3));
    check_val("z_idle",     512'(csr_rd_data[1]),   512'(64'd0));

    // Overflow: one active, four queued, sixth dropped
    apply_reset();
    setup_job(64'h1000, 64'h2000, 64'd256);
    s0 = start_cnt;
    repeat (6) csr_write(CSR_DOORBELL, 64'd0);
    check_val("ovf_status", 512'(csr_rd_data[1]),   512'(64'h184));
    for (int i = 0; i < 5; i++) begin
      pulse_done();
      repeat (4) @(negedge clk);
    end
    check_val("ovf_cnt",    512'(csr_rd_data[0]),   512'(64'd5));
    check_val("ovf_starts", 512'(start_cnt - s0),   512'(5));
    check_val("ovf_sticky", 512'(csr_rd_data[1]),   512'(64'h100));
    csr_write(CSR_DOORBELL, 64'h8000_0000_0000_0000);
    repeat (3) @(negedge clk);
    check_val("ovf_clear",  512'(csr_rd_data[1]),   512'(64'd0));
    check_val("ovf_nopush", 512'(start_cnt - s0),   512'(5));

    // Push coinciding with a pop while full
    apply_reset();
    setup_job(64'h1000, 64'h2000, 64'd256);
    repeat (5) csr_write(CSR_DOORBELL, 64'd0);
    check_val("fp_full",    512'(csr_rd_data[1]),   512'(64'h084));
    pulse_done();
    csr_write(CSR_DOORBELL, 64'd0);
    @(negedge clk);
    check_val("fp_status",  512'(csr_rd_data[1]),   512'(64'h084));
    check_val("fp_cnt",     512'(csr_rd_data[0]),   512'(64'd1));

    // Mode 0 passes a beat through unchanged
    x0 = xfer_cnt;
    bus.wr_ready = 1'b1;
    @(negedge clk);
    bus.rd_data  = pat_d;
    bus.rd_valid = 1'b1;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    @(negedge clk);
    check_val("cp_xfers",   512'(xfer_cnt - x0),    512'(1));
    check_val("cp_data",    xfer_last,              pat_d);

    // Mode 1 inversion under backpressure
    apply_reset();
    setup_job(64'h1000, 64'h2000, 64'd256);
    csr_write(CSR_DOORBELL, 64'd1);
    repeat (3) @(negedge clk);
    x0 = xfer_cnt;
    @(negedge clk);
    bus.wr_ready = 1'b0;
    bus.rd_data  = pat_a5;
    bus.rd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) bus.rd_data = pat_3c;
      #1;
      check_val("bp_wvalid", 512'(bus.wr_valid), 512'(1'b1));
      check_val("bp_hold",   bus.wr_data,        pat_5a);
      check_val("bp_rready", 512'(bus.rd_ready), 512'(1'b0));
    end
    check_val("bp_noxfer",  512'(xfer_cnt - x0),    512'(0));
    bus.wr_ready = 1'b1;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    @(negedge clk);
    check_val("bp_xfers",   512'(xfer_cnt - x0),    512'(2));
    check_val("bp_first",   xfer_prev,              pat_5a);
    check_val("bp_second",  xfer_last,              pat_c3);
    check_val("bp_drained", 512'(bus.wr_valid),     512'(1'b0));

    // Reset while busy with two queued jobs and a held beat
    apply_reset();
    setup_job(64'h1000, 64'h2000, 64'd256);
    repeat (3) csr_write(CSR_DOORBELL, 64'd0);
    check_val("mr_status",  512'(csr_rd_data[1]),   512'(64'h082));
    @(negedge clk);
    bus.wr_ready = 1'b0;
    bus.rd_data  = pat_a5;
    bus.rd_valid = 1'b1;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    check_val("mr_wv_pre",  512'(bus.wr_valid),     512'(1'b1));
    s0 = start_cnt;
    apply_reset();
    #1;
    check_val("mr_cnt",     512'(csr_rd_data[0]),   512'(64'd0));
    check_val("mr_status0", 512'(csr_rd_data[1]),   512'(64'd0));
    check_val("mr_src",     512'(csr_rd_data[2]),   512'(64'd0));
    check_val("mr_dst",     512'(csr_rd_data[3]),   512'(64'd0));
    check_val("mr_lines",   512'(csr_rd_data[4]),   512'(64'd0));
    check_val("mr_start",   512'(bus.dma_start),    512'(1'b0));
    check_val("mr_wvalid",  512'(bus.wr_valid),     512'(1'b0));
    check_val("mr_dmalen",  512'(bus.dma_len),      512'(26'd0));
    bus.wr_ready = 1'b1;
    pulse_done();
    repeat (3) @(negedge clk);
    check_val("mr_late_done", 512'(csr_rd_data[0]), 512'(64'd0));
    check_val("mr_idle",      512'(csr_rd_data[1]), 512'(64'd0));
    check_val("mr_nostart",   512'(start_cnt - s0), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end
endmodule
